// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM responder FSM state type.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    TRANS_IDLE   = HTRANS_IDLE,
    TRANS_BUSY   = HTRANS_BUSY,
    TRANS_NONSEQ = HTRANS_NONSEQ,
    TRANS_SEQ    = HTRANS_SEQ
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = HSIZE_BYTE,
    SIZE_HALF = HSIZE_HALF,
    SIZE_WORD = HSIZE_WORD
  } hsize_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb3lite_byte_lane_dec.sv
// Little-endian byte-enable decode from transfer size and low address bits.
module ahb3lite_byte_lane_dec
  import ahb3lite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] byte_en,
  output logic       misaligned
);

  always_comb begin
    byte_en    = 4'b1111;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: byte_en = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        // A half at offset 3 keeps only lane 3 (truncated shift).
        byte_en    = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default:    misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM responder with configurable wait states.
// Define AHB3LITE_SLV_ERRRESP_EN to return ERROR on misaligned/illegal/out-of-range accesses.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

  slv_state_e       state_reg, state_next, launch_state;
  logic [3:0]       cnt_reg, cnt_next, launch_cnt;
  logic [IDX_W-1:0] addr_idx_reg;
  logic             wr_reg;
  logic [3:0]       be_reg;
  logic             oor_reg;
  logic [3:0]       fwd_be_reg;
  logic [31:0]      fwd_data_reg;
  logic [31:0]      rd_merged;

  logic             accept;
  logic [3:0]       be_dec;
  logic             misaligned;
  logic [IDX_W-1:0] idx_in;
  logic             oor_in;
  logic             wr_fire;
  logic             hazard;

  wire unused_inputs = &{1'b0, HBURST, HPROT, HTRANS[0], misaligned};

  ahb3lite_byte_lane_dec u_lane_dec (
    .hsize      (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .byte_en    (be_dec),
    .misaligned (misaligned)
  );

  assign accept = HSEL & HREADY & HTRANS[1];
  assign idx_in = HADDR[IDX_W+1:2];
  assign oor_in = ({1'b0, HADDR} >= ADDR_LIMIT);

`ifdef AHB3LITE_SLV_ERRRESP_EN
  logic err_in;
  assign err_in = misaligned | (HSIZE > HSIZE_WORD) | oor_in;
`endif

  // The write commits on the closing edge of DATA; a reset on that edge cancels it.
  assign wr_fire = (state_reg == SLV_DATA) & wr_reg & ~oor_reg & HRESETn;
  assign hazard  = wr_fire & accept & ~HWRITE & ~oor_in & (idx_in == addr_idx_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge HCLK) begin
        if (wr_fire && be_reg[gi]) begin
          mem_lane[addr_idx_reg] <= HWDATA[8*gi +: 8];
        end
        if (accept) begin
          rd_lane_reg <= mem_lane[idx_in];
        end
      end

      assign rd_merged[8*gi +: 8] = fwd_be_reg[gi] ? fwd_data_reg[8*gi +: 8] : rd_lane_reg;
    end
  endgenerate

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg    <= SLV_IDLE;
      cnt_reg      <= '0;
      addr_idx_reg <= '0;
      wr_reg       <= 1'b0;
      be_reg       <= '0;
      oor_reg      <= 1'b0;
      fwd_be_reg   <= '0;
      fwd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_idx_reg <= idx_in;
        wr_reg       <= HWRITE;
        be_reg       <= be_dec;
        oor_reg      <= oor_in;
        // Lanes the retiring write touches override the stale array read.
        fwd_be_reg   <= hazard ? be_reg : 4'b0000;
        fwd_data_reg <= HWDATA;
      end
    end
  end

  always_comb begin
    launch_state = SLV_IDLE;
    launch_cnt   = '0;
    if (accept) begin
      if (WAIT_STATES > 0) begin
        launch_state = SLV_WAIT;
        launch_cnt   = 4'(WAIT_STATES);
      end else begin
        launch_state = SLV_DATA;
      end
`ifdef AHB3LITE_SLV_ERRRESP_EN
      if (err_in) begin
        launch_state = SLV_ERR1;
        launch_cnt   = '0;
      end
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    HRDATA     = '0;
    case (state_reg)
      SLV_IDLE: begin
        state_next = launch_state;
        cnt_next   = launch_cnt;
      end
      SLV_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_next  = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = SLV_DATA;
        end
      end
      SLV_DATA: begin
        if (!wr_reg && !oor_reg) begin
          HRDATA = rd_merged;
        end
        state_next = launch_state;
        cnt_next   = launch_cnt;
      end
`ifdef AHB3LITE_SLV_ERRRESP_EN
      SLV_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = SLV_ERR2;
      end
      SLV_ERR2: begin
        HRESP      = HRESP_ERROR;
        state_next = launch_state;
        cnt_next   = launch_cnt;
      end
`endif
      default: begin
        state_next = SLV_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: a zero-wait and a three-wait instance on one bus.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic        hclk    = 1'b0;
  logic        hresetn = 1'b0;
  logic        use3    = 1'b0;
  logic        hsel    = 1'b0;
  logic        hwrite  = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [1:0]  htrans  = 2'b00;
  logic [2:0]  hsize   = 3'b000;
  logic [2:0]  hburst  = 3'b000;
  logic [3:0]  hprot   = 4'b0011;
  logic [31:0] hwdata  = '0;

  logic        ro0, ro3, rs0, rs3;
  logic [31:0] rd0, rd3;

  wire        hready  = use3 ? ro3 : ro0;
  wire        hresp_m = use3 ? rs3 : rs0;
  wire [31:0] hrdata_m = use3 ? rd3 : rd0;

  always #5 hclk = ~hclk;

  ahb3lite_sram_slave #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel & ~use3), .HADDR(haddr),
    .HWRITE(hwrite), .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb3lite_sram_slave #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel & use3), .HADDR(haddr),
    .HWRITE(hwrite), .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3)
  );

  typedef struct {
    logic [1:0]    trans;
    logic          wr;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } xfer_t;

  typedef struct {
    int          id;
    logic        chk_rd;
    logic [31:0] rdata;
    int          waits;
    logic        resp;
  } exp_t;

  xfer_t       tq[$];
  exp_t        sb[$];
  logic [31:0] model [0:1][0:DEPTH-1];
  int          errors = 0;
  int          checks = 0;
  int          xfer_id = 0;
  string       cur_tag = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                     input logic [AW-1:0] addr, input logic [31:0] wdata,
                     input logic [2:0] burst = 3'b000);
    xfer_t x;
    x.trans = trans; x.wr = wr; x.size = size; x.burst = burst;
    x.addr = addr;   x.wdata = wdata;
    tq.push_back(x);
  endtask

  // Reference behaviour, evaluated in issue order so a later read sees earlier writes.
  task automatic predict(input xfer_t x, output exp_t e);
    int   d, a, i;
    logic oor, err;
    d = use3 ? 1 : 0;
    a = int'(x.addr[1:0]);
    i = int'(x.addr[11:2]);
    oor = (int'(x.addr) >= DEPTH * 4);
    e.id = xfer_id++;
    e.chk_rd = 1'b0; e.rdata = '0; e.waits = 0; e.resp = 1'b0;
    if (x.trans[1]) begin
      err = 1'b0;
`ifdef AHB3LITE_SLV_ERRRESP_EN
      err = oor || (x.size > 3'd2) || (x.size == 3'd1 && a[0]) || (x.size == 3'd2 && a != 0);
`endif
      if (err) begin
        e.waits = 1; e.resp = 1'b1; e.chk_rd = 1'b1; e.rdata = '0;
      end else begin
        e.waits = use3 ? 3 : 0;
        if (x.wr) begin
          if (!oor) begin
            for (int b = 0; b < 4; b++) begin
              logic en;
              case (x.size)
                3'd0:    en = (b == a);
                3'd1:    en = (b == a) || (b == a + 1);
                default: en = 1'b1;
              endcase
              if (en) model[d][i][8*b +: 8] = x.wdata[8*b +: 8];
            end
          end
        end else begin
          e.chk_rd = 1'b1;
          e.rdata  = oor ? 32'h0 : model[d][i];
        end
      end
    end
  endtask

  task automatic check_dp(input int w);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (w === e.waits) else begin
      errors++;
      $error("FAIL %s#%0d waits: observed=%0d expected=%0d", cur_tag, e.id, w, e.waits);
    end
    checks++;
    assert (hresp_m === e.resp) else begin
      errors++;
      $error("FAIL %s#%0d hresp: observed=%b expected=%b", cur_tag, e.id, hresp_m, e.resp);
    end
    if (e.chk_rd) begin
      checks++;
      assert (hrdata_m === e.rdata) else begin
        errors++;
        $error("FAIL %s#%0d hrdata: observed=%h expected=%h", cur_tag, e.id, hrdata_m, e.rdata);
      end
    end
    $display("xfer %s#%0d waits=%0d resp=%b rdata=%h", cur_tag, e.id, w, hresp_m, hrdata_m);
  endtask

  // Pipelined master: each loop drives one address phase while the previous data phase runs.
  task automatic run_queue();
    xfer_t       a;
    exp_t        e;
    logic        have_dp, issued;
    logic [31:0] next_wdata;
    int          w;
    have_dp = 1'b0;
    next_wdata = hwdata;
    while (tq.size() > 0 || have_dp) begin
      issued = 1'b0;
      if (tq.size() > 0) begin
        a = tq.pop_front();
        hsel = 1'b1; htrans = a.trans; hwrite = a.wr; hsize = a.size;
        hburst = a.burst; haddr = a.addr;
        predict(a, e);
        sb.push_back(e);
        issued = 1'b1;
        next_wdata = a.wdata;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      end
      w = 0;
      @(negedge hclk);
      while (!hready && w < 40) begin
        w++;
        @(negedge hclk);
      end
      if (have_dp) check_dp(w);
      @(posedge hclk); #1;
      hwdata  = next_wdata;
      have_dp = issued;
    end
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst ro0", 32'(ro0), 32'h1);
    chk("rst rs0", 32'(rs0), 32'h0);
    chk("rst rd0", rd0, 32'h0);
    chk("rst ro3", 32'(ro3), 32'h1);
    chk("rst rs3", 32'(rs3), 32'h0);
    chk("rst rd3", rd3, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;

    use3 = 1'b0;
    cur_tag = "t1_word";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'h0ABBABBA);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0020, 32'h0);
    run_queue();

    cur_tag = "t2_idle";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0024, 32'h00000000);
    add(HTRANS_IDLE,   1'b1, HSIZE_WORD, 16'h0020, 32'hDEADBEEF);
    add(HTRANS_IDLE,   1'b1, HSIZE_WORD, 16'h0024, 32'hDEADBEEF);
    add(HTRANS_BUSY,   1'b1, HSIZE_WORD, 16'h0024, 32'hDEADBEEF);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0024, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0020, 32'h0);
    run_queue();

    cur_tag = "t3_lanes";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0040, 32'h00000000);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0041, 32'h00005500);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 16'h0042, 32'h12340000);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0040, 32'h0);
    run_queue();

    cur_tag = "t5_fwd";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0010, 32'hA5A5A5A5);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0014, 32'h11223344);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0015, 32'h0000AA00);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0014, 32'h0);
    run_queue();

    cur_tag = "edge_cases";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0000, 32'h13579BDF);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0050, 32'h00000000);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h1000, 32'hFFFFFFFF);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h1000, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0000, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0022, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, 3'd3,       16'h0050, 32'h600DF00D);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0050, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0FFC, 32'h0);
    run_queue();

    use3 = 1'b1;
    cur_tag = "t4_wrap4";
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0020, 32'hA0A0A0A0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0024, 32'hB1B1B1B1);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0028, 32'hC2C2C2C2);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h002C, 32'hD3D3D3D3);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h002C, 32'h0, BURST_WRAP4);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h0020, 32'h0, BURST_WRAP4);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h0024, 32'h0, BURST_WRAP4);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 16'h0028, 32'h0, BURST_WRAP4);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0030, 32'hCAFEF00D);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0030, 32'h0);
    run_queue();

    // Reset lands on the closing edge of a write data phase: the write must not commit.
    cur_tag = "rst_mid";
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    hburst = BURST_SINGLE; haddr = 16'h0030;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
    w = 0;
    @(negedge hclk);
    while (!ro3 && w < 40) begin
      w++;
      @(negedge hclk);
    end
    chk("rst_mid waits", 32'(w), 32'd3);
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    chk("rst_mid ro3", 32'(ro3), 32'h1);
    chk("rst_mid rs3", 32'(rs3), 32'h0);
    chk("rst_mid rd3", rd3, 32'h0);
    @(posedge hclk); #1;
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0030, 32'h0);
    run_queue();

`ifdef AHB3LITE_SLV_ERRRESP_EN
    use3 = 1'b0;
    cur_tag = "t6_err";
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 16'h0022;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("err1 ro0", 32'(ro0), 32'h0);
    chk("err1 rs0", 32'(rs0), 32'h1);
    @(negedge hclk);
    chk("err2 ro0", 32'(ro0), 32'h1);
    chk("err2 rs0", 32'(rs0), 32'h1);
    chk("err2 rd0", rd0, 32'h0);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 16'h0022;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("rst_err1 pre rs0", 32'(rs0), 32'h1);
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    chk("rst_err1 ro0", 32'(ro0), 32'h1);
    chk("rst_err1 rs0", 32'(rs0), 32'h0);
    @(posedge hclk); #1;
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h1000, 32'h77777777);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0000, 32'h0);
    run_queue();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB-Lite responder: a single-port word-organised SRAM that answers the transfers issued by the bus master interface (`ahb_if` transfer task).
- Accepts NONSEQ/SEQ transfers and supports byte, halfword and word accesses.
- Inserts a configurable number of wait states.
- Returns OKAY, or optionally a two-cycle ERROR response.
- Sits behind the address decoder as the memory slave that the smoke tests read and write.

Parameters:
- ADDR_WIDTH, 16: HADDR width in bits.
- DEPTH, 1024: number of 32-bit words. Must be a power of 2 and satisfy DEPTH*4 <= 2**ADDR_WIDTH.
- WAIT_STATES, 0: number of HREADYOUT-low cycles per accepted transfer, range 0..15.

Ports:
- HCLK  in  1  bus clock; everything is sampled on the rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address (address phase).
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; values >2 are illegal.
- HBURST  in  3  accepted but ignored; the master generates every beat address, including WRAP4.
- HPROT  in  4  accepted but ignored.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready; the address phase is valid only when HREADY=1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset (HRESETn=0 at a rising edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM -> IDLE, wait counter=0.
  - A pending write is dropped.
  - Memory contents are not reset.
  - Reset mid-transfer aborts the transfer; no partial write occurs.
- Accept condition: HSEL & HREADY & HTRANS[1]. On acceptance, latch addr, write, size and byte-enables.
- IDLE and BUSY transfers, or HSEL=0:
  - No memory access.
  - The next data phase is zero-wait OKAY.
- Byte enables, little-endian:
  - byte: 1 << HADDR[1:0]
  - half: 4'b0011 << HADDR[1:0]
  - word: 4'b1111
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> WAIT on accept when WAIT_STATES>0; counter loads WAIT_STATES; HREADYOUT=0.
  - IDLE -> DATA on accept when WAIT_STATES=0.
  - WAIT: counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Write: HWDATA lanes selected by byte-enables are written at the closing edge.
    - Read: HRDATA holds the addressed word (all 32 bits, not masked).
    - In the same cycle, a new accept -> WAIT or DATA as from IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1; a new address phase is sampled here as usual.
- Read-after-write hazard: a read whose data phase directly follows a write to the same word returns the merged new data, with byte-lane forwarding, in the same cycle. No extra wait state is added.
- Latency with WAIT_STATES=N: each transfer's data phase lasts N+1 cycles. Back-to-back transfers with N=0 sustain one transfer per cycle.
- Address out of range (addr >= DEPTH*4) without the optional feature:
  - Writes are dropped.
  - Reads return 0.
  - Response is OKAY.
- Memory is indexed by addr[log2(DEPTH)+1:2].

Optional Feature:
AHB3LITE_SLV_ERRRESP_EN.
- Defined: misaligned access, HSIZE>2, or out-of-range address produces the two-cycle ERROR response.
  - Path: accept -> ERR1 -> ERR2. Wait states are skipped.
  - No memory write occurs.
  - HRDATA=0.
- Undefined:
  - ERR1 and ERR2 are not compiled.
  - HRESP is tied to 0.
  - Misaligned accesses use the truncated byte-enables; HSIZE>2 is treated as word.

Decomposition:
- Add to ahb3lite_pkg:
  - htrans, hsize and hburst enums (reuse the existing HTRANS_*/HSIZE_* constants).
  - HRESP_OKAY and HRESP_ERROR.
  - The slave FSM state enum.
- One sub-module, ahb3lite_byte_lane_dec: combinational {HSIZE, HADDR[1:0]} -> 4-bit byte-enable plus misaligned flag.

Test Plan:
1. Reset, then write word 0x0ABBABBA at 0x20, then read 0x20 -> HRDATA=0x0ABBABBA, HRESP=0, each data phase one cycle.
2. IDLE-type writes of 0xDEADBEEF to 0x20/0x24 after a clean memory, then NONSEQ read 0x24 -> returns the old value; no write happened.
3. Byte write 0x55 to 0x41, half write 0x1234 to 0x42 (word previously 0), read 0x40 -> 0x12345500.
4. WAIT_STATES=3, WRAP4 reads at 0x2C, 0x20, 0x24, 0x28 -> HREADYOUT low for exactly 3 cycles per beat, with correct data on each beat.
5. Back-to-back write 0xA5A5A5A5 at 0x10 then read 0x10, N=0 -> forwarded 0xA5A5A5A5 in the next cycle.
6. With AHB3LITE_SLV_ERRRESP_EN: word read at 0x22 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Write at DEPTH*4 -> ERROR, memory unchanged. Asserting HRESETn=0 during ERR1 -> next cycle HREADYOUT=1, HRESP=0.
